// File: rtl/game_ctrl.sv
// Game sequencer for the bird/pipe datapath: reset pulse, run/freeze control,
// click gating, and current/high score bookkeeping.
module game_ctrl #(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned OVER_FRAMES = 60,
  parameter int unsigned SCORE_W     = 10,
  parameter int unsigned SCORE_MAX   = 999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mouse_left,
  input  logic               collision,
  input  logic               pipe_passed,
  input  logic               frame_tick,
  output logic               game_rst,
  output logic               mouse_left_game,
  output logic               game_active,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);

  localparam int unsigned CNT_MAX = (RST_CYCLES > OVER_FRAMES) ? RST_CYCLES : OVER_FRAMES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [SCORE_W-1:0] score_nxt, high_nxt;
  logic               mouse_left_prev;
  logic               click;
  logic               game_rst_nxt, game_active_nxt, mouse_left_game_nxt;

  assign click = mouse_left & ~mouse_left_prev;
  assign state = state_q;

  // Shared counter: reset-pulse length in START, frame lockout in OVER.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    score_nxt = score;
    high_nxt  = high_score;
    case (state_q)
      IDLE: begin
        if (click) begin
          state_nxt = START;
          cnt_nxt   = CNT_W'(RST_CYCLES - 1);
          score_nxt = '0;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_nxt = PLAY;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      PLAY: begin
        if (collision) begin
          state_nxt = OVER;
          cnt_nxt   = CNT_W'(OVER_FRAMES);
          if (score > high_score) begin
            high_nxt = score;
          end
        end else if (pipe_passed && (score < SCORE_W'(SCORE_MAX))) begin
          score_nxt = score + SCORE_W'(1);
        end
      end
      OVER: begin
        if (click && (cnt_q == '0)) begin
          state_nxt = START;
          cnt_nxt   = CNT_W'(RST_CYCLES - 1);
          score_nxt = '0;
        end else if (frame_tick && (cnt_q != '0)) begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    game_rst_nxt        = (state_nxt == START);
    game_active_nxt     = (state_nxt == PLAY);
    mouse_left_game_nxt = game_active_nxt & mouse_left;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      score           <= '0;
      high_score      <= '0;
      mouse_left_prev <= 1'b0;
      game_rst        <= 1'b0;
      game_active     <= 1'b0;
      mouse_left_game <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      cnt_q           <= cnt_nxt;
      score           <= score_nxt;
      high_score      <= high_nxt;
      mouse_left_prev <= mouse_left;
      game_rst        <= game_rst_nxt;
      game_active     <= game_active_nxt;
      mouse_left_game <= mouse_left_game_nxt;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus random play, checked every cycle
// against a phase-level model of the game rules.
module tb_game_ctrl;

  localparam int RST_CYCLES  = 4;
  localparam int OVER_FRAMES = 60;
  localparam int SCORE_MAX   = 999;

  logic       clk = 1'b0;
  logic       rst;
  logic       mouse_left, collision, pipe_passed, frame_tick;
  logic       game_rst, mouse_left_game, game_active;
  logic [1:0] state;
  logic [9:0] score, high_score;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left), .collision(collision),
    .pipe_passed(pipe_passed), .frame_tick(frame_tick), .game_rst(game_rst),
    .mouse_left_game(mouse_left_game), .game_active(game_active), .state(state),
    .score(score), .high_score(high_score)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: game phase (0 idle,1 start,2 play,3 over), reset cycles left, frames left.
  int m_phase = 0, m_rem = 0, m_lock = 0, m_score = 0, m_high = 0;
  bit m_prev = 0, e_mlg = 0;

  always @(posedge clk or negedge rst) begin : model
    bit clk_click;
    if (!rst) begin
      m_phase = 0; m_rem = 0; m_lock = 0; m_score = 0; m_high = 0;
      m_prev = 0; e_mlg = 0;
    end else begin
      clk_click = mouse_left && !m_prev;
      m_prev = mouse_left;
      case (m_phase)
        0: if (clk_click) begin m_phase = 1; m_rem = RST_CYCLES; m_score = 0; end
        1: begin m_rem--; if (m_rem == 0) m_phase = 2; end
        2: if (collision) begin
             if (m_score > m_high) m_high = m_score;
             m_lock = OVER_FRAMES; m_phase = 3;
           end else if (pipe_passed) begin
             m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
           end
        default: if (clk_click && m_lock == 0) begin
                   m_phase = 1; m_rem = RST_CYCLES; m_score = 0;
                 end else if (frame_tick && m_lock > 0) begin
                   m_lock--;
                 end
      endcase
      e_mlg = (m_phase == 2) && mouse_left;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      cmp("state", state, m_phase);
      cmp("game_rst", game_rst, m_phase == 1);
      cmp("game_active", game_active, m_phase == 2);
      cmp("mouse_left_game", mouse_left_game, e_mlg);
      cmp("score", score, m_score);
      cmp("high_score", high_score, m_high);
    end
  end

  task automatic pipes(input int n);
    for (int i = 0; i < n; i++) begin
      pipe_passed = 1'b1; @(negedge clk);
      pipe_passed = 1'b0; @(negedge clk);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; @(negedge clk);
      frame_tick = 1'b0; @(negedge clk);
    end
  endtask

  task automatic crash();
    collision = 1'b1; @(negedge clk);
    collision = 1'b0; @(negedge clk);
  endtask

  task automatic click_start();
    mouse_left = 1'b1; @(negedge clk);
    cmp("click_start_state", state, 1);
    cmp("click_start_score", score, 0);
    mouse_left = 1'b0; @(negedge clk);
  endtask

  task automatic wait_play();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (state == 2'd2) begin ok = 1; break; end
      @(negedge clk);
    end
    cmp("wait_play_timeout", ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mouse_left = 1'b0; collision = 1'b0; pipe_passed = 1'b0; frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    cmp("rst_state", state, 0);
    cmp("rst_game_rst", game_rst, 0);
    cmp("rst_mlg", mouse_left_game, 0);
    cmp("rst_active", game_active, 0);
    cmp("rst_score", score, 0);
    cmp("rst_high", high_score, 0);
    rst = 1'b1;
    @(negedge clk);

    // Held press: one START entry, game_rst for 4 cycles, then PLAY.
    begin
      int grc = 0, starts = 0;
      logic [1:0] prev_s = 2'd0;
      mouse_left = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (i == 2) mouse_left = 1'b0;
        if (game_rst) grc++;
        if (state == 2'd1 && prev_s != 2'd1) starts++;
        prev_s = state;
        if (state == 2'd2) break;
      end
      cmp("game_rst_len", grc, 4);
      cmp("start_entries", starts, 1);
      cmp("play_state", state, 2);
      cmp("play_active", game_active, 1);
    end

    pipes(5);
    cmp("score_5", score, 5);
    crash();
    cmp("over_state", state, 3);
    cmp("over_high", high_score, 5);
    mouse_left = 1'b1; @(negedge clk); @(negedge clk);
    cmp("over_mlg", mouse_left_game, 0);
    mouse_left = 1'b0; @(negedge clk);

    frames(10);
    mouse_left = 1'b1; @(negedge clk); mouse_left = 1'b0; @(negedge clk);
    cmp("locked_click", state, 3);
    frames(50);
    click_start();
    wait_play();
    pipes(3);
    crash();
    cmp("low_game_score", score, 3);
    cmp("low_game_high", high_score, 5);

    frames(60);
    click_start();
    wait_play();
    pipes(7);
    pipe_passed = 1'b1; collision = 1'b1; @(negedge clk);
    pipe_passed = 1'b0; collision = 1'b0; @(negedge clk);
    cmp("tie_state", state, 3);
    cmp("tie_score", score, 7);
    cmp("tie_high", high_score, 7);

    frames(60);
    click_start();
    wait_play();
    pipes(998);
    cmp("score_998", score, 998);
    pipes(3);
    cmp("score_sat", score, 999);
    crash();
    cmp("high_999", high_score, 999);

    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(3) == 0) mouse_left = ~mouse_left;
      collision   = ($urandom_range(63) == 0);
      pipe_passed = ($urandom_range(7) == 0);
      frame_tick  = ($urandom_range(2) == 0);
      @(negedge clk);
    end

    // Drive toward START, then reset asynchronously mid-pulse.
    begin
      bit reached = 0;
      pipe_passed = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        if (state == 2'd1) begin reached = 1; break; end
        collision  = (state == 2'd2);
        frame_tick = 1'b1;
        mouse_left = (state == 2'd0 || state == 2'd3) ? ~mouse_left : 1'b0;
        @(negedge clk);
      end
      cmp("reach_start_timeout", reached, 1);
    end
    mouse_left = 1'b0; collision = 1'b0; frame_tick = 1'b0;
    cmp("pre_rst_game_rst", game_rst, 1);
    cmp("pre_rst_high", high_score, 999);
    #2 rst = 1'b0;
    #1;
    cmp("async_game_rst", game_rst, 0);
    cmp("async_state", state, 0);
    cmp("async_high", high_score, 0);
    cmp("async_active", game_active, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    cmp("post_rst_state", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer: decides when the bird/pipe datapath is reset, running or frozen.
- Drives game_rst and the gated click into the bird drawing/physics path.
- Consumes that path's collision flag and a per-pipe "passed" pulse.
- Keeps current score and high score for the score overlay; sits between mouse input logic and the drawing pipeline.

Parameters:
- RST_CYCLES, 4: length in clk cycles of the game_rst pulse issued on every new game.
- OVER_FRAMES, 60: frame_tick count after a crash during which clicks are ignored.
- SCORE_W, 10: width of score and high_score.
- SCORE_MAX, 999: saturation value of score.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  asynchronous, active-low reset.
- mouse_left  in  1  left button level, already synchronised to clk.
- collision  in  1  level from bird physics; high while bird hits floor, ceiling or pipe.
- pipe_passed  in  1  single-cycle pulse when the bird clears a pipe.
- frame_tick  in  1  single-cycle pulse once per video frame.
- game_rst  out  1  active-high reset to bird/pipe datapath.
- mouse_left_game  out  1  click forwarded to bird physics.
- game_active  out  1  high only in PLAY.
- state  out  2  IDLE=0, START=1, PLAY=2, OVER=3.
- score  out  SCORE_W  current score.
- high_score  out  SCORE_W  best score since reset.

Behaviour:
Reset (rst low, asynchronous):
- state=IDLE, game_rst=0, mouse_left_game=0, game_active=0, score=0, high_score=0.
- Internal counters and edge-detect register cleared.
- Assertion mid-game aborts immediately, including during START or OVER.

Click detection:
- click = mouse_left & ~mouse_left_d, where mouse_left_d is a registered copy.
- One click per press; holding the button does not repeat.

FSM, all transitions on posedge clk:
- IDLE: score holds its last value. On click -> START, clear score to 0, load rst counter = RST_CYCLES-1.
- START: game_rst=1 for exactly RST_CYCLES cycles, registered so it is asserted the cycle after entry. Counter decrements each cycle; at 0 -> PLAY. Clicks ignored. collision ignored, because the datapath is being reset.
- PLAY:
  - mouse_left_game = mouse_left, registered, 1-cycle latency. It is 0 in every other state.
  - game_active=1.
  - pipe_passed with no collision in the same cycle -> score+1, saturating at SCORE_MAX.
  - collision=1 -> OVER on the next edge.
  - collision and pipe_passed in the same cycle: collision wins, score unchanged.
  - On the OVER transition, load lockout counter = OVER_FRAMES. If score > high_score, high_score <= score in the same cycle; ties leave it unchanged.
- OVER:
  - Score frozen, game_active=0, game_rst=0.
  - Lockout counter decrements on each frame_tick down to 0.
  - A click while counter != 0 is discarded, not queued.
  - A click with counter == 0 -> START, score cleared.
  - OVER_FRAMES=0 allows an immediate restart on the next click.
- Illegal state encodings recover to IDLE.

Outputs:
- All outputs are registered; no combinational input-to-output path.
- pipe_passed and frame_tick are ignored outside the states listed above.

Test Plan:
1. Release rst, click once (mouse_left high 3 cycles) -> START, game_rst high exactly 4 cycles, then PLAY with game_active=1. Only one START entry.
2. In PLAY, 5 pipe_passed pulses -> score=5. Then collision -> OVER, high_score=5, mouse_left_game stays 0 afterwards.
3. In OVER, click after 10 frame_ticks -> ignored. Click after 60 frame_ticks -> START and score=0. Finish a game with score 3 -> high_score stays 5.
4. pipe_passed and collision in the same cycle at score=7 -> OVER with score=7 and high_score=7.
5. Force score to 998, then 3 pipe_passed pulses -> score=999 (saturates).
6. Assert rst in the middle of START (game_rst=1) -> game_rst=0 and state=IDLE immediately, without waiting for a clock edge. high_score=0.
